sreg_receptor: RTL

Serial-to-parallel receiver for the stream produced by the 4-bit shift register's `S_OUT` in serial-load or rotation mode. It samples one bit per enabled clock, reassembles frames of `WIDTH` bits in the order given by `DIR`, and presents each word on a valid/ready output. It sits at the far end of the serial link, feeding the parallel consumer.

---
 rtl/sreg_receptor.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sreg_receptor.sv
// rtl/sreg_receptor.sv - serial-to-parallel frame receiver with valid/ready output
//
// Reassembles WIDTH-bit frames from a one-bit serial stream, sampled on
// ENB cycles, and presents each completed word on a registered valid/ready
// output stage. It never back-pressures the serial link.
//
// Optional feature macro: SREG_RX_PARITY_EN. When defined, each frame is
// followed by one even-parity bit (captured in state PAR) and PERR reports
// the parity check for the word held in Q. When undefined, PERR is 0.
//
// Ports:
//   CLK      in   clock, rising edge
//   RST_L    in   synchronous active-low reset
//   ENB      in   bit strobe; low freezes all frame state
//   START    in   first bit of a frame (with ENB); aborts any frame in progress
//   DIR      in   bit order, latched with START: 0 MSB first, 1 LSB first
//   S_IN     in   serial data
//   READY    in   consumer accepts Q while VALID
//   Q        out  received word
//   VALID    out  Q holds an unconsumed word
//   BUSY     out  frame in progress
//   OVERRUN  out  sticky: a completed word was dropped
//   PERR     out  parity error flag for the word in Q
module sreg_receptor #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_L,
  input  logic             ENB,
  input  logic             START,
  input  logic             DIR,
  input  logic             S_IN,
  input  logic             READY,
  output logic [WIDTH-1:0] Q,
  output logic             VALID,
  output logic             BUSY,
  output logic             OVERRUN,
  output logic             PERR
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef SREG_RX_PARITY_EN
  localparam logic [1:0] ST_PAR   = 2'd2;
`endif

  // Count of captured data bits; 5 bits covers WIDTH up to 16.
  localparam logic [4:0] CNT_LAST = 5'(WIDTH);

  logic [1:0]       state;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] sh;
  logic             dir_r;

  logic [WIDTH-1:0] sh_next;
  logic [WIDTH-1:0] word;
  logic             word_perr;
  logic             done;
  logic             last_bit;

  // Completion is decoded from current state and this cycle's inputs so the
  // output stage can load on the very edge that captures the last bit.
  always_comb begin
    sh_next   = dir_r ? {S_IN, sh[WIDTH-1:1]} : {sh[WIDTH-2:0], S_IN};
    last_bit  = (state == ST_SHIFT) && ((cnt + 5'd1) == CNT_LAST);
    done      = 1'b0;
    word      = sh_next;
    word_perr = 1'b0;
    // START always wins: an aborted frame never delivers.
    if (ENB && !START) begin
`ifdef SREG_RX_PARITY_EN
      if (state == ST_PAR) begin
        done      = 1'b1;
        word      = sh;
        word_perr = (^sh) ^ S_IN;
      end
`else
      done = last_bit;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_L) begin
      state   <= ST_IDLE;
      cnt     <= 5'd0;
      sh      <= '0;
      dir_r   <= 1'b0;
      Q       <= '0;
      VALID   <= 1'b0;
      OVERRUN <= 1'b0;
      PERR    <= 1'b0;
    end else begin
      // Frame assembly
      if (ENB) begin
        if (START) begin
          // Clear the rest of the register so a restarted frame carries no
          // leftovers from the aborted one.
          dir_r <= DIR;
          cnt   <= 5'd1;
          state <= ST_SHIFT;
          sh    <= DIR ? {S_IN, {(WIDTH-1){1'b0}}} : {{(WIDTH-1){1'b0}}, S_IN};
        end else begin
          case (state)
            ST_SHIFT: begin
              sh <= sh_next;
              if (last_bit) begin
                cnt <= 5'd0;
`ifdef SREG_RX_PARITY_EN
                state <= ST_PAR;
`else
                state <= ST_IDLE;
`endif
              end else begin
                cnt <= cnt + 5'd1;
              end
            end
`ifdef SREG_RX_PARITY_EN
            ST_PAR: state <= ST_IDLE;
`endif
            default: ;
          endcase
        end
      end

      // Output stage: a full, unconsumed slot drops the new word.
      if (done) begin
        if (!VALID || READY) begin
          Q     <= word;
          VALID <= 1'b1;
          PERR  <= word_perr;
        end else begin
          OVERRUN <= 1'b1;
        end
      end else if (VALID && READY) begin
        VALID <= 1'b0;
      end
    end
  end

  assign BUSY = (state != ST_IDLE);

endmodule
